// File: rtl/alu_operand_sequencer.sv
// -----------------------------------------------------------------------------
// alu_operand_sequencer
//
// Board-side operand entry for an external ALU. Three raw buttons (step,
// enable, clear) are synchronised and debounced. A four-state FSM then uses
// the switch bank to capture operand A, operand B and the opcode/flag word.
// After that it latches the ALU result and flags for the display and the LEDs.
//
// Ports
//   clk, rst_n      system clock, asynchronous active-low reset
//   sw              switch bank, sampled only on a capture edge
//   btn_step        raw step button (acts only while btn_en is held)
//   btn_en          raw enable button
//   btn_clr         raw clear button
//   f_in, nzcv_in   result and flags from the external ALU
//   a, b            operands to the ALU
//   alu_op, cf, vf,
//   shift_cout      opcode and carry/overflow/shift-carry inputs to the ALU
//   disp_data       {value, valid} word for the 7-segment display
//   nzcv            latched ALU flags for the LEDs
//   state           current FSM state for the LEDs
//   result_valid    high for the single cycle in which the result is latched
// -----------------------------------------------------------------------------
module alu_operand_sequencer #(
  parameter int WIDTH           = 32,
  parameter int OP_W            = 4,
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw,
  input  logic             btn_step,
  input  logic             btn_en,
  input  logic             btn_clr,
  input  logic [WIDTH-1:0] f_in,
  input  logic [3:0]       nzcv_in,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [OP_W-1:0]  alu_op,
  output logic             cf,
  output logic             vf,
  output logic             shift_cout,
  output logic [WIDTH:0]   disp_data,
  output logic [3:0]       nzcv,
  output logic [1:0]       state,
  output logic             result_valid
);

  typedef enum logic [1:0] {
    S_A   = 2'd0,
    S_B   = 2'd1,
    S_OP  = 2'd2,
    S_RES = 2'd3
  } state_t;

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Bit positions of the three buttons inside the conditioning vectors.
  localparam int I_STEP = 0;
  localparam int I_EN   = 1;
  localparam int I_CLR  = 2;

  state_t           st;
  logic [2:0]       raw;
  logic [2:0]       sync1;
  logic [2:0]       sync2;
  logic [2:0]       deb;
  logic [2:0]       deb_q;
  logic [CNT_W-1:0] cnt [3];
  logic             step_evt;
  logic             clr_evt;

  assign raw   = {btn_clr, btn_en, btn_step};
  assign state = st;

  // Input conditioning: a 2-FF synchroniser feeds a debouncer. The debouncer
  // counts consecutive synchronised samples that differ from the accepted
  // level. Any sample that agrees with the accepted level restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_q <= '0;
      // NOTE: this is a three-entry counter bank, not a RAM. Resetting it
      // guarantees that a level held through reset debounces from a known
      // count.
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments let sync2 take the old sync1. This is
      // what makes the two flops a real two-stage synchroniser.
      sync1 <= raw;
      sync2 <= sync1;
      deb_q <= deb;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Each event lasts for the first cycle of a debounced high level.
  // The enable qualifier is applied at that edge only. A step edge seen
  // without enable is lost for good.
  assign step_evt = deb[I_STEP] & ~deb_q[I_STEP] & deb[I_EN];
  assign clr_evt  = deb[I_CLR]  & ~deb_q[I_CLR];

  // Operand sequencer. result_valid is high for exactly the first S_RES cycle.
  // It also marks the cycle in which f_in/nzcv_in are latched, which gives the
  // ALU one full cycle to settle after the opcode capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st           <= S_A;
      a            <= '0;
      b            <= '0;
      alu_op       <= '0;
      cf           <= 1'b0;
      vf           <= 1'b0;
      shift_cout   <= 1'b0;
      nzcv         <= '0;
      disp_data    <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (clr_evt) begin
        // Clear overrides a step that arrives in the same cycle.
        st         <= S_A;
        a          <= '0;
        b          <= '0;
        alu_op     <= '0;
        cf         <= 1'b0;
        vf         <= 1'b0;
        shift_cout <= 1'b0;
        nzcv       <= '0;
        disp_data  <= '0;
      end else begin
        if (st == S_RES && result_valid) begin
          disp_data <= {f_in, 1'b1};
          nzcv      <= nzcv_in;
        end
        if (step_evt) begin
          case (st)
            S_A: begin
              a         <= sw;
              disp_data <= {sw, 1'b1};
              st        <= S_B;
            end
            S_B: begin
              b         <= sw;
              disp_data <= {sw, 1'b1};
              st        <= S_OP;
            end
            S_OP: begin
              {alu_op, cf, vf, shift_cout} <= sw[WIDTH-1 -: OP_W+3];
              result_valid                 <= 1'b1;
              st                           <= S_RES;
            end
            S_RES: begin
              // Hold everything so the display keeps showing the result.
              st <= S_A;
            end
            default: st <= S_A;
          endcase
        end
      end
    end
  end

endmodule

// File: doc/alu_operand_sequencer.md
Name: alu_operand_sequencer

Overview:
Parametrised, clock-synchronous successor to the board-level ALU operand entry logic. It synchronises and debounces the step, enable and clear buttons, then walks a 4-state FSM that captures operand A, operand B and the op/flag word from the switches. It latches the external ALU result and drives the operand/flag inputs of the external ALU, the 7-seg display data word and status LEDs. It sits between board I/O and the ALU/Display instances.

Parameters:
WIDTH, 32, operand/result width in bits (>=8)
OP_W, 4, ALU opcode width
DEBOUNCE_CYCLES, 20000, consecutive stable samples required to accept a button level (>=2)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
sw  input  WIDTH  switch bank; sw[WIDTH-1] is MSB
btn_step  input  1  raw step button, active-high
btn_en  input  1  raw enable button; a step only acts while this is held
btn_clr  input  1  raw clear button, active-high
f_in  input  WIDTH  result from external ALU
nzcv_in  input  4  flags from external ALU
a  output  WIDTH  operand A to ALU
b  output  WIDTH  operand B to ALU
alu_op  output  OP_W  opcode to ALU
cf  output  1  carry-in flag to ALU
vf  output  1  overflow-in flag to ALU
shift_cout  output  1  shift carry-out to ALU
disp_data  output  WIDTH+1  {value, valid}; to Display
nzcv  output  4  latched flags for LEDs
state  output  2  current FSM state for LEDs
result_valid  output  1  one-cycle pulse when result latched

Behaviour:
- Reset (async, rst_n=0): a, b, alu_op, cf, vf, shift_cout, nzcv, disp_data = 0; state = S_A; result_valid = 0; all sync/debounce registers and counters = 0.
- Input conditioning, per button: 2-FF synchroniser, then debouncer. The debounced level changes only after DEBOUNCE_CYCLES consecutive identical synchronised samples differing from the current level. Any glitch restarts the counter.
- step_evt: one-cycle pulse on the debounced btn_step rising edge while debounced btn_en = 1. If en is not held, the edge is discarded; releasing en later does not replay it.
- clr_evt: debounced btn_clr rising edge. en is not required.
- Latency: raw press stable → sync 2 cycles → debounce DEBOUNCE_CYCLES → event cycle → registers update on the following clk edge.
- FSM (state encoding S_A=0, S_B=1, S_OP=2, S_RES=3):
  - S_A + step_evt: a <= sw; disp_data <= {sw,1}; → S_B.
  - S_B + step_evt: b <= sw; disp_data <= {sw,1}; → S_OP.
  - S_OP + step_evt: {alu_op,cf,vf,shift_cout} <= sw[WIDTH-1 -: OP_W+3] (MSB-aligned); → S_RES. disp_data is unchanged this cycle.
  - S_RES, first cycle after entry: disp_data <= {f_in,1}; nzcv <= nzcv_in; result_valid = 1 for exactly this cycle. This gives the ALU one full cycle to settle.
  - S_RES + step_evt: → S_A. No capture; a, b, op and result are held, so the display keeps showing the result until the next A capture.
  - In S_RES after the latch cycle, f_in/nzcv_in changes are ignored.
- clr_evt in any state: → S_A; a, b, alu_op, cf, vf, shift_cout, nzcv = 0; disp_data = {WIDTH{1'b0},0}; no result_valid.
- Simultaneous clr_evt and step_evt in the same cycle: clear wins; the step is dropped.
- step_evt on the entry cycle of S_RES: the result latch and pulse still occur, and the state goes to S_A on the same edge.
- Reset asserted mid-sequence: immediate return to reset values. Debounced levels restart at 0, so a button held through reset release produces one event once it is debounced.
- sw is sampled only on the capture edge and needs no synchroniser (operator holds it stable).

Test Plan:
- DEBOUNCE_CYCLES=4, btn_en held, sw=32'h0000_0005 step, sw=32'h0000_0003 step, sw=32'h2000_0000 step (op=0010, flags 000), ALU model f_in=A-B=2, nzcv=4'b0010 → a=5, b=3, alu_op=4'b0010; one cycle after S_RES entry disp_data={32'h2,1}, nzcv=0010, single result_valid pulse; state sequence 0,1,2,3.
- Bounce: btn_step toggles every 2 cycles for 20 cycles then stays high → exactly one step_evt; a captured once.
- Step with btn_en low, sw=32'hDEAD_BEEF → state stays S_A, a=0, disp_data=0.
- In S_B press clr and step in the same cycle → state S_A, a=b=0, disp_data=0, no B capture.
- Fourth step from S_RES → state S_A, disp_data keeps {f,1}. The next step with sw=32'h7 → a=7, disp_data={32'h7,1}.
- rst_n pulsed low for 1 cycle, asynchronously mid-cycle in S_OP → all outputs 0 immediately, state S_A, no result_valid afterwards.
